// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage pipeline. It steers the PC enable,
// the IF/ID load and flush, and the ID/EX bubble from load-use hazards,
// taken branches resolved in EX and instruction-memory wait. It also keeps
// saturating counters of stall cycles and flush sequences.
module pipeline_hazard_ctrl #(
   parameter int unsigned BRANCH_PENALTY = 2,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             imem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_FLUSH     = 2'd1;
   localparam logic [1:0] ST_IMEM_WAIT = 2'd2;

   localparam logic             HAS_FLUSH  = (BRANCH_PENALTY > 1);
   localparam logic [2:0]       FLUSH_LOAD = 3'(BRANCH_PENALTY - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [2:0]       fcnt_q, fcnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] fev_q, fev_d;

   logic load_use;
   logic pw_c, iw_c, fl_c, bb_c;
   logic flush_start;

   // Load-use hazard: EX load writes a register the ID instruction reads
   always_comb begin
      load_use = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   end

   // Control outputs and next state; a taken branch overrides everything
   always_comb begin
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      pw_c        = 1'b1;
      iw_c        = 1'b1;
      fl_c        = 1'b0;
      bb_c        = 1'b0;
      flush_start = 1'b0;
      if (ex_branch_taken) begin
         fl_c        = 1'b1;
         bb_c        = 1'b1;
         flush_start = 1'b1;
         if (HAS_FLUSH) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_LOAD;
         end else begin
            state_d = ST_RUN;
            fcnt_d  = '0;
         end
      end else if (state_q == ST_FLUSH) begin
         fl_c = 1'b1;
         bb_c = 1'b1;
         pw_c = imem_ready;
         if (imem_ready) begin
            if (fcnt_q <= 3'd1) begin
               state_d = ST_RUN;
               fcnt_d  = '0;
            end else begin
               fcnt_d = fcnt_q - 3'd1;
            end
         end
      end else begin
         // RUN, IMEM_WAIT and the unused encoding share the RUN outputs;
         // only the next-state choice differs for the unused encoding.
         if (!imem_ready || load_use) begin
            pw_c = 1'b0;
            iw_c = 1'b0;
            bb_c = 1'b1;
         end
         if ((state_q == ST_RUN) || (state_q == ST_IMEM_WAIT)) begin
            state_d = imem_ready ? ST_RUN : ST_IMEM_WAIT;
         end else begin
            state_d = ST_RUN;
         end
      end
   end

   // Saturating performance counters
   always_comb begin
      stall_d = stall_q;
      fev_d   = fev_q;
      if (!pw_c && (stall_q != CNT_MAX)) begin
         stall_d = stall_q + CNT_ONE;
      end
      if (flush_start && (fev_q != CNT_MAX)) begin
         fev_d = fev_q + CNT_ONE;
      end
   end

   // State and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
         stall_q <= '0;
         fev_q   <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         stall_q <= stall_d;
         fev_q   <= fev_d;
      end
   end

   // Output drive; reset forces a held, flushed pipeline front end
   always_comb begin
      if (reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         pc_write    = pw_c;
         ifid_write  = iw_c;
         ifid_flush  = fl_c;
         idex_bubble = bb_c;
      end
      state        = state_q;
      stall_cycles = stall_q;
      flush_events = fev_q;
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenario tasks plus a
// randomized run checked against a cycle-level reference model. Two
// instances share all inputs: A (penalty 2, 16-bit counters) and
// B (penalty 1, 4-bit counters).
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, ex_branch_taken, imem_ready;

   logic        pc_write_a, ifid_write_a, ifid_flush_a, idex_bubble_a;
   logic [1:0]  state_a;
   logic [15:0] stall_a, fev_a;
   logic        pc_write_b, ifid_write_b, ifid_flush_b, idex_bubble_b;
   logic [1:0]  state_b;
   logic [3:0]  stall_b, fev_b;

   logic [3:0] ctl_a, ctl_b;
   assign ctl_a = {pc_write_a, ifid_write_a, ifid_flush_a, idex_bubble_a};
   assign ctl_b = {pc_write_b, ifid_write_b, ifid_flush_b, idex_bubble_b};

   int checks   = 0;
   int failures = 0;

   // model: remaining post-branch flush cycles, memory-wait flag, counters
   int m_fl[2];
   bit m_wait[2];
   int m_stall[2];
   int m_fev[2];
   int bp[2]   = '{2, 1};
   int cmax[2] = '{65535, 15};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.BRANCH_PENALTY(2), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
      .pc_write(pc_write_a), .ifid_write(ifid_write_a),
      .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a),
      .state(state_a), .stall_cycles(stall_a), .flush_events(fev_a));

   pipeline_hazard_ctrl #(.BRANCH_PENALTY(1), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
      .pc_write(pc_write_b), .ifid_write(ifid_write_b),
      .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b),
      .state(state_b), .stall_cycles(stall_b), .flush_events(fev_b));

   // expected {pc_write, ifid_write, ifid_flush, idex_bubble, state}
   function automatic logic [5:0] exp_out(input int k);
      logic       lu;
      logic [1:0] st;
      lu = ex_mem_read && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      st = (m_fl[k] > 0) ? 2'd1 : (m_wait[k] ? 2'd2 : 2'd0);
      if (ex_branch_taken)      return {4'b1111, st};
      if (m_fl[k] > 0)          return {imem_ready, 3'b111, st};
      if (!imem_ready || lu)    return {4'b0001, st};
      return {4'b1100, st};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_fl[k] = 0; m_wait[k] = 0; m_stall[k] = 0; m_fev[k] = 0;
      end
   endtask

   task automatic model_tick();
      logic [5:0] e;
      for (int k = 0; k < 2; k++) begin
         e = exp_out(k);
         if (!e[5] && m_stall[k] < cmax[k]) m_stall[k]++;
         if (ex_branch_taken) begin
            if (m_fev[k] < cmax[k]) m_fev[k]++;
            m_fl[k]   = bp[k] - 1;
            m_wait[k] = 0;
         end else if (m_fl[k] > 0) begin
            if (imem_ready) m_fl[k]--;
         end else begin
            m_wait[k] = !imem_ready;
         end
      end
   endtask

   task automatic advance();
      model_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      ex_branch_taken = 0; imem_ready = 1; ex_mem_read = 0;
      ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   task automatic test_reset();
      set_idle();
      reset = 1;
      #1;
      checks++;
      if (ctl_a !== 4'b0011) begin
         failures++;
         $display("FAIL reset_outputs: got %b want %b", ctl_a, 4'b0011);
      end
      do_reset();
      #3;
      checks++;
      if ({state_a, stall_a, fev_a} !== 34'd0) begin
         failures++;
         $display("FAIL reset_state: got st=%0d stall=%0d fev=%0d want 0/0/0", state_a, stall_a, fev_a);
      end
      // async reset mid-cycle while in FLUSH
      ex_branch_taken = 1;
      advance();
      ex_branch_taken = 0;
      #1;
      reset = 1;
      model_reset();
      #1;
      checks++;
      if ({ctl_a, state_a, fev_a} !== {4'b0011, 2'd0, 16'd0}) begin
         failures++;
         $display("FAIL reset_mid_flush: got ctl=%b st=%0d fev=%0d want ctl=0011 st=0 fev=0", ctl_a, state_a, fev_a);
      end
      @(posedge clk);
      #1;
      reset = 0;
      #3;
      checks++;
      if ({ctl_a, state_a, stall_a, fev_a} !== {4'b1100, 2'd0, 16'd0, 16'd0}) begin
         failures++;
         $display("FAIL reset_release: got ctl=%b st=%0d stall=%0d fev=%0d want 1100/0/0/0", ctl_a, state_a, stall_a, fev_a);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      ex_mem_read = 1; ex_rt = 5; id_rs = 5;
      #3;
      checks++;
      if ({ctl_a, state_a} !== {4'b0001, 2'd0}) begin
         failures++;
         $display("FAIL load_use_stall: got ctl=%b st=%0d want 0001/0", ctl_a, state_a);
      end
      advance();
      ex_mem_read = 0;
      #3;
      checks++;
      if ({ctl_a, stall_a} !== {4'b1100, 16'd1}) begin
         failures++;
         $display("FAIL load_use_release: got ctl=%b stall=%0d want 1100/1", ctl_a, stall_a);
      end
      advance();
      ex_mem_read = 1; ex_rt = 0; id_rs = 0;
      #3;
      checks++;
      if (ctl_a !== 4'b1100) begin
         failures++;
         $display("FAIL load_use_r0: got %b want 1100", ctl_a);
      end
      advance();
      ex_rt = 7; id_rt = 7; id_rs = 3; id_uses_rt = 1;
      #3;
      checks++;
      if (ctl_a !== 4'b0001) begin
         failures++;
         $display("FAIL load_use_rt: got %b want 0001", ctl_a);
      end
      advance();
      id_uses_rt = 0;
      #3;
      checks++;
      if ({ctl_a, stall_a} !== {4'b1100, 16'd2}) begin
         failures++;
         $display("FAIL load_use_rt_unused: got ctl=%b stall=%0d want 1100/2", ctl_a, stall_a);
      end
      advance();
   endtask

   task automatic test_branch();
      do_reset();
      ex_branch_taken = 1;
      #3;
      checks++;
      if ({ctl_a, state_a, ctl_b} !== {4'b1111, 2'd0, 4'b1111}) begin
         failures++;
         $display("FAIL branch_cycle: got a=%b st=%0d b=%b want 1111/0/1111", ctl_a, state_a, ctl_b);
      end
      advance();
      ex_branch_taken = 0;
      #3;
      checks++;
      if ({ctl_a, state_a, ctl_b, state_b} !== {4'b1111, 2'd1, 4'b1100, 2'd0}) begin
         failures++;
         $display("FAIL branch_flush: got a=%b st=%0d b=%b stb=%0d want 1111/1/1100/0", ctl_a, state_a, ctl_b, state_b);
      end
      advance();
      #3;
      checks++;
      if ({ctl_a, state_a, fev_a, stall_a, fev_b} !== {4'b1100, 2'd0, 16'd1, 16'd0, 4'd1}) begin
         failures++;
         $display("FAIL branch_done: got ctl=%b st=%0d fev=%0d stall=%0d fevb=%0d want 1100/0/1/0/1", ctl_a, state_a, fev_a, stall_a, fev_b);
      end
      advance();
   endtask

   task automatic test_branch_wait();
      int nfl = 0;
      int npw0 = 0;
      do_reset();
      ex_branch_taken = 1;
      #3;
      nfl += int'(ifid_flush_a); npw0 += int'(!pc_write_a);
      advance();
      ex_branch_taken = 0;
      imem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #3;
         nfl += int'(ifid_flush_a); npw0 += int'(!pc_write_a);
         checks++;
         if ({ctl_a, state_a} !== {4'b0111, 2'd1}) begin
            failures++;
            $display("FAIL branch_wait_hold: got ctl=%b st=%0d want 0111/1", ctl_a, state_a);
         end
         advance();
      end
      imem_ready = 1;
      #3;
      nfl += int'(ifid_flush_a); npw0 += int'(!pc_write_a);
      advance();
      #3;
      nfl += int'(ifid_flush_a);
      checks++;
      if ({nfl, npw0, int'(stall_a), int'(state_a)} !== {32'd5, 32'd3, 32'd3, 32'd0}) begin
         failures++;
         $display("FAIL branch_wait_totals: got flush=%0d pw0=%0d stall=%0d st=%0d want 5/3/3/0", nfl, npw0, stall_a, state_a);
      end
      advance();
   endtask

   task automatic test_back_to_back();
      do_reset();
      ex_branch_taken = 1; ex_mem_read = 1; ex_rt = 4; id_rs = 4;
      #3;
      checks++;
      if ({ctl_a, state_a} !== {4'b1111, 2'd0}) begin
         failures++;
         $display("FAIL priority_branch_lu: got ctl=%b st=%0d want 1111/0", ctl_a, state_a);
      end
      advance();
      ex_mem_read = 0;
      advance();
      ex_branch_taken = 0;
      #3;
      checks++;
      if ({ctl_a, state_a} !== {4'b1111, 2'd1}) begin
         failures++;
         $display("FAIL back_to_back_restart: got ctl=%b st=%0d want 1111/1", ctl_a, state_a);
      end
      advance();
      #3;
      checks++;
      if ({ctl_a, state_a, fev_a, stall_a} !== {4'b1100, 2'd0, 16'd2, 16'd0}) begin
         failures++;
         $display("FAIL back_to_back_done: got ctl=%b st=%0d fev=%0d stall=%0d want 1100/0/2/0", ctl_a, state_a, fev_a, stall_a);
      end
      advance();
   endtask

   task automatic test_imem_wait();
      do_reset();
      imem_ready = 0; ex_mem_read = 1; ex_rt = 9; id_rs = 9;
      #3;
      checks++;
      if ({ctl_a, state_a} !== {4'b0001, 2'd0}) begin
         failures++;
         $display("FAIL imem_wait_enter: got ctl=%b st=%0d want 0001/0", ctl_a, state_a);
      end
      advance();
      ex_mem_read = 0;
      #3;
      checks++;
      if ({ctl_a, state_a} !== {4'b0001, 2'd2}) begin
         failures++;
         $display("FAIL imem_wait_hold: got ctl=%b st=%0d want 0001/2", ctl_a, state_a);
      end
      advance();
      imem_ready = 1; ex_mem_read = 1;
      #3;
      checks++;
      if ({ctl_a, state_a} !== {4'b0001, 2'd2}) begin
         failures++;
         $display("FAIL imem_wait_exit_lu: got ctl=%b st=%0d want 0001/2", ctl_a, state_a);
      end
      advance();
      ex_mem_read = 0;
      #3;
      checks++;
      if ({ctl_a, state_a, stall_a} !== {4'b1100, 2'd0, 16'd3}) begin
         failures++;
         $display("FAIL imem_wait_done: got ctl=%b st=%0d stall=%0d want 1100/0/3", ctl_a, state_a, stall_a);
      end
      advance();
   endtask

   task automatic test_saturation();
      do_reset();
      imem_ready = 0;
      for (int i = 0; i < 20; i++) advance();
      set_idle();
      #3;
      checks++;
      if ({stall_b, stall_a} !== {4'd15, 16'd20}) begin
         failures++;
         $display("FAIL stall_saturation: got b=%0d a=%0d want 15/20", stall_b, stall_a);
      end
      advance();
   endtask

   task automatic test_random();
      logic [5:0] ea, eb;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         imem_ready      = ($urandom_range(0, 3) != 0);
         ex_mem_read     = $urandom_range(0, 1) == 1;
         ex_rt           = 5'($urandom_range(0, 3));
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         id_uses_rt      = $urandom_range(0, 1) == 1;
         #3;
         ea = exp_out(0);
         eb = exp_out(1);
         checks++;
         if ({ctl_a, state_a, ctl_b, state_b} !== {ea, eb}) begin
            failures++;
            $display("FAIL random_ctl cyc=%0d: got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d",
                     i, ctl_a, state_a, ctl_b, state_b, ea[5:2], ea[1:0], eb[5:2], eb[1:0]);
         end
         checks++;
         if ({stall_a, fev_a, stall_b, fev_b} !==
             {16'(m_stall[0]), 16'(m_fev[0]), 4'(m_stall[1]), 4'(m_fev[1])}) begin
            failures++;
            $display("FAIL random_cnt cyc=%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     i, stall_a, fev_a, stall_b, fev_b, m_stall[0], m_fev[0], m_stall[1], m_fev[1]);
         end
         advance();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_use();
      test_branch();
      test_branch_wait();
      test_back_to_back();
      test_imem_wait();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
